stamofu_launch_arbiter: RTL and testbench
=========================================

Name: stamofu_launch_arbiter

Overview:
- Schedules ops into the store-AMO-fence launch pipeline REQ stage.
- Selects oldest-first among central queue (CQ) entries ready to launch and misaligned queue (MQ) entries ready to launch their second half.
- Registers the selection and holds it stable until the pipeline acks it.
- Includes an anti-starvation counter so CQ launches are not indefinitely blocked by MQ traffic.

Parameters:
- CQ_ENTRIES, 16, central queue depth (power of 2); CQ_W = log2(CQ_ENTRIES)
- MQ_ENTRIES, 4, misaligned queue depth (power of 2); MQ_W = log2(MQ_ENTRIES)
- STARVE_LIMIT, 4, max consecutive MQ grants while any CQ request is pending (>=1)

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- cq_req_mask  in  CQ_ENTRIES  per-entry CQ launch request
- cq_head  in  CQ_W  CQ oldest-entry index
- mq_req_mask  in  MQ_ENTRIES  per-entry MQ launch request
- mq_head  in  MQ_W  MQ oldest-entry index
- launch_valid  out  1  registered request to REQ stage
- launch_is_mq  out  1  selected entry is MQ
- launch_cq_index  out  CQ_W  selected CQ index (valid when !launch_is_mq)
- launch_mq_index  out  MQ_W  selected MQ index (valid when launch_is_mq)
- launch_ack  in  1  REQ stage accepted current launch
- cq_launch_done_valid  out  1  pulse: CQ entry launched
- cq_launch_done_index  out  CQ_W  launched CQ index
- mq_launch_done_valid  out  1  pulse: MQ entry launched
- mq_launch_done_index  out  MQ_W  launched MQ index

Behaviour:
- Reset: all outputs 0; starve_cnt = 0.
- Output register is "free" when !launch_valid or (launch_valid && launch_ack). Arbitrate only when free; otherwise hold all launch_* outputs unchanged.
- Held-entry kill: if the held entry's mask bit is 0 while launch_valid && !launch_ack, treat the register as free and re-arbitrate that cycle.
- Oldest-first selection per queue:
  - rotate the mask right by head, priority-encode the lowest set bit, then index = (head + offset) mod depth (wrap-around).
  - Mask out the index currently being acked, so the same-cycle stale bit is not reselected.
  - The owning queue must clear the bit by the cycle after the done pulse.
- Queue select:
  - MQ wins by default, since it completes an already-launched op.
  - Exception: CQ wins if starve_cnt == STARVE_LIMIT and any CQ request is pending.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each MQ grant while any CQ request is pending;
  - clears on any CQ grant, or when no CQ request is pending.
- Latency: a request bit set in cycle t can be launch_valid in t+1.
- Done pulses: combinational in the ack cycle (launch_valid && launch_ack), carrying the held index; exactly one pulse per ack.
- Both masks zero while free: launch_valid = 0 next cycle; index outputs hold their last value.
- Back-to-back: an ack in cycle t with another request pending gives a new launch_valid in t+1 (no bubble).
- Reset mid-operation (nRST low): immediately clears launch_valid, starve_cnt and the done pulses; no done pulse is issued for a held entry.

Optional Feature:
- Macro: STAMOFU_LAUNCH_ARB_STATS_EN.
- When defined, adds three outputs, each 32 bits, saturating, reset to 0:
  - stat_cq_grants, incremented on CQ acks;
  - stat_mq_grants, incremented on MQ acks;
  - stat_stall_cycles, incremented each cycle with launch_valid && !launch_ack.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- cq_head=14, cq_req_mask bits 2 and 15 set, mq empty -> launch_cq_index=15 first (wrap, oldest); after ack, index 2 the next cycle.
- launch_valid held with launch_ack=0 for 5 cycles while a new mq bit asserts -> outputs unchanged, no done pulse; after ack, MQ granted next cycle.
- mq_req_mask=4'b1111 held, cq bit 3 set, STARVE_LIMIT=4, immediate acks -> four MQ grants, then CQ index 3, starve_cnt back to 0.
- Held CQ index 5, bit 5 deasserts before ack, bit 7 set -> next cycle launch_cq_index=7, no done pulse for 5.
- Ack with the acked bit still set that cycle and no other requests -> launch_valid=0 next cycle (no duplicate launch).
- nRST asserted while launch_valid=1 -> launch_valid=0 immediately; after release, relaunch from current masks.

Source files
------------

// File: rtl/stamofu_launch_arbiter_if.sv
// Launch-arbiter handshake bundle: queue request masks/heads in, registered launch and done pulses out.
// Optional statistics signals exist only when STAMOFU_LAUNCH_ARB_STATS_EN is defined.
interface stamofu_launch_arbiter_if #(
    parameter int CQ_ENTRIES = 16,
    parameter int MQ_ENTRIES = 4
);
    localparam int CQ_W = $clog2(CQ_ENTRIES);
    localparam int MQ_W = $clog2(MQ_ENTRIES);

    logic [CQ_ENTRIES-1:0] cq_req_mask;
    logic [CQ_W-1:0]       cq_head;
    logic [MQ_ENTRIES-1:0] mq_req_mask;
    logic [MQ_W-1:0]       mq_head;

    logic                  launch_valid;
    logic                  launch_is_mq;
    logic [CQ_W-1:0]       launch_cq_index;
    logic [MQ_W-1:0]       launch_mq_index;
    logic                  launch_ack;

    logic                  cq_launch_done_valid;
    logic [CQ_W-1:0]       cq_launch_done_index;
    logic                  mq_launch_done_valid;
    logic [MQ_W-1:0]       mq_launch_done_index;

`ifdef STAMOFU_LAUNCH_ARB_STATS_EN
    logic [31:0]           stat_cq_grants;
    logic [31:0]           stat_mq_grants;
    logic [31:0]           stat_stall_cycles;
`endif

    // Arbiter side.
    modport slave (
`ifdef STAMOFU_LAUNCH_ARB_STATS_EN
        output stat_cq_grants, stat_mq_grants, stat_stall_cycles,
`endif
        input  cq_req_mask, cq_head, mq_req_mask, mq_head, launch_ack,
        output launch_valid, launch_is_mq, launch_cq_index, launch_mq_index,
        output cq_launch_done_valid, cq_launch_done_index,
        output mq_launch_done_valid, mq_launch_done_index
    );

    // Queue / pipeline side.
    modport master (
`ifdef STAMOFU_LAUNCH_ARB_STATS_EN
        input  stat_cq_grants, stat_mq_grants, stat_stall_cycles,
`endif
        output cq_req_mask, cq_head, mq_req_mask, mq_head, launch_ack,
        input  launch_valid, launch_is_mq, launch_cq_index, launch_mq_index,
        input  cq_launch_done_valid, cq_launch_done_index,
        input  mq_launch_done_valid, mq_launch_done_index
    );
endinterface

// File: rtl/stamofu_launch_arbiter.sv
// Oldest-first CQ/MQ launch arbiter for the store-AMO-fence REQ stage with MQ-starvation guard.
// Define STAMOFU_LAUNCH_ARB_STATS_EN to add saturating grant/stall statistics counters.
module stamofu_launch_arbiter #(
    parameter int CQ_ENTRIES   = 16,
    parameter int MQ_ENTRIES   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    stamofu_launch_arbiter_if.slave   bus
);
    localparam int CQ_W = $clog2(CQ_ENTRIES);
    localparam int MQ_W = $clog2(MQ_ENTRIES);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    logic            launch_valid_q;
    logic            launch_is_mq_q;
    logic [CQ_W-1:0] cq_idx_q;
    logic [MQ_W-1:0] mq_idx_q;
    logic [SW-1:0]   starve_cnt_q;

    logic                  ack_fire;
    logic                  held_bit;
    logic                  held_killed;
    logic                  free;
    logic [CQ_ENTRIES-1:0] cq_ack_onehot;
    logic [MQ_ENTRIES-1:0] mq_ack_onehot;
    logic [CQ_ENTRIES-1:0] cq_avail;
    logic [MQ_ENTRIES-1:0] mq_avail;
    logic [CQ_ENTRIES-1:0] cq_rot;
    logic [MQ_ENTRIES-1:0] mq_rot;
    logic [CQ_W-1:0]       cq_off;
    logic [MQ_W-1:0]       mq_off;
    logic [CQ_W-1:0]       cq_sel;
    logic [MQ_W-1:0]       mq_sel;
    logic                  cq_any;
    logic                  mq_any;
    logic                  starved;
    logic                  pick_cq;

    assign ack_fire    = launch_valid_q & bus.launch_ack;
    assign held_bit    = launch_is_mq_q ? bus.mq_req_mask[mq_idx_q] : bus.cq_req_mask[cq_idx_q];
    // A held entry whose request vanished is dropped and the slot re-arbitrated in the same cycle.
    assign held_killed = launch_valid_q & ~bus.launch_ack & ~held_bit;
    assign free        = ~launch_valid_q | bus.launch_ack | held_killed;

    // The acked entry's bit is still set this cycle; hide it so it is not launched twice.
    assign cq_ack_onehot = (ack_fire && !launch_is_mq_q) ? (CQ_ENTRIES'(1) << cq_idx_q) : '0;
    assign mq_ack_onehot = (ack_fire &&  launch_is_mq_q) ? (MQ_ENTRIES'(1) << mq_idx_q) : '0;
    assign cq_avail      = bus.cq_req_mask & ~cq_ack_onehot;
    assign mq_avail      = bus.mq_req_mask & ~mq_ack_onehot;
    assign cq_any        = |cq_avail;
    assign mq_any        = |mq_avail;

    // Rotate so the head lands at bit 0; the lowest set bit is then the oldest request.
    assign cq_rot = CQ_ENTRIES'({cq_avail, cq_avail} >> bus.cq_head);
    assign mq_rot = MQ_ENTRIES'({mq_avail, mq_avail} >> bus.mq_head);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cq_off = '0;
        for (int i = CQ_ENTRIES - 1; i >= 0; i--) begin
            if (cq_rot[i]) cq_off = CQ_W'(i);
        end
    end

    always_comb begin
        mq_off = '0;
        for (int i = MQ_ENTRIES - 1; i >= 0; i--) begin
            if (mq_rot[i]) mq_off = MQ_W'(i);
        end
    end

    // Depths are powers of two, so the index add wraps modulo depth for free.
    assign cq_sel  = bus.cq_head + cq_off;
    assign mq_sel  = bus.mq_head + mq_off;

    assign starved = (starve_cnt_q == SW'(STARVE_LIMIT));
    assign pick_cq = cq_any && (!mq_any || starved);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            launch_valid_q <= 1'b0;
            launch_is_mq_q <= 1'b0;
            cq_idx_q       <= '0;
            mq_idx_q       <= '0;
            starve_cnt_q   <= '0;
        end else begin
            if (free) begin
                launch_valid_q <= cq_any | mq_any;
                if (pick_cq) begin
                    launch_is_mq_q <= 1'b0;
                    cq_idx_q       <= cq_sel;
                end else if (mq_any) begin
                    launch_is_mq_q <= 1'b1;
                    mq_idx_q       <= mq_sel;
                end
            end

            if (!cq_any || (free && pick_cq)) begin
                starve_cnt_q <= '0;
            end else if (free && mq_any && !starved) begin
                starve_cnt_q <= starve_cnt_q + SW'(1);
            end
        end
    end

    assign bus.launch_valid         = launch_valid_q;
    assign bus.launch_is_mq         = launch_is_mq_q;
    assign bus.launch_cq_index      = cq_idx_q;
    assign bus.launch_mq_index      = mq_idx_q;
    assign bus.cq_launch_done_valid = ack_fire & ~launch_is_mq_q;
    assign bus.cq_launch_done_index = cq_idx_q;
    assign bus.mq_launch_done_valid = ack_fire & launch_is_mq_q;
    assign bus.mq_launch_done_index = mq_idx_q;

`ifdef STAMOFU_LAUNCH_ARB_STATS_EN
    logic [31:0] stat_cq_q;
    logic [31:0] stat_mq_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_cq_q    <= '0;
            stat_mq_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            if (bus.cq_launch_done_valid && stat_cq_q != '1) stat_cq_q <= stat_cq_q + 32'd1;
            if (bus.mq_launch_done_valid && stat_mq_q != '1) stat_mq_q <= stat_mq_q + 32'd1;
            if (launch_valid_q && !bus.launch_ack && stat_stall_q != '1)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign bus.stat_cq_grants    = stat_cq_q;
    assign bus.stat_mq_grants    = stat_mq_q;
    assign bus.stat_stall_cycles = stat_stall_q;
`endif
endmodule

// File: tb/tb_stamofu_launch_arbiter.sv
// Directed bench for stamofu_launch_arbiter: expected launches are queued as stimulus is driven
// and popped when the arbiter presents them.
module tb_stamofu_launch_arbiter;
    logic CLK;
    logic nRST;

    stamofu_launch_arbiter_if #(.CQ_ENTRIES(16), .MQ_ENTRIES(4)) bus ();

    stamofu_launch_arbiter #(.CQ_ENTRIES(16), .MQ_ENTRIES(4), .STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_mq;
        int unsigned idx;
    } launch_t;

    launch_t exp_q[$];
    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input bit is_mq, input int unsigned idx);
        launch_t e;
        e.is_mq = is_mq;
        e.idx   = idx;
        exp_q.push_back(e);
    endtask

    task automatic check_done(input string tag, input bit cq_v, input int unsigned cq_i,
                              input bit mq_v, input int unsigned mq_i);
        check({tag, "_cq_done_v"}, {31'd0, bus.cq_launch_done_valid}, {31'd0, cq_v});
        if (cq_v) check({tag, "_cq_done_i"}, {28'd0, bus.cq_launch_done_index}, cq_i);
        check({tag, "_mq_done_v"}, {31'd0, bus.mq_launch_done_valid}, {31'd0, mq_v});
        if (mq_v) check({tag, "_mq_done_i"}, {30'd0, bus.mq_launch_done_index}, mq_i);
    endtask

    task automatic pop_compare(input string tag, input bit ack_now);
        launch_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed valid=%0b", tag, bus.launch_valid);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, bus.launch_valid}, 32'd1);
            check({tag, "_is_mq"}, {31'd0, bus.launch_is_mq}, {31'd0, e.is_mq});
            if (e.is_mq) check({tag, "_mq_idx"}, {30'd0, bus.launch_mq_index}, e.idx);
            else         check({tag, "_cq_idx"}, {28'd0, bus.launch_cq_index}, e.idx);
            if (ack_now) check_done(tag, !e.is_mq, e.idx, e.is_mq, e.idx);
            else         check_done(tag, 1'b0, 0, 1'b0, 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST            = 1'b0;
        bus.cq_req_mask = '0;
        bus.cq_head     = '0;
        bus.mq_req_mask = '0;
        bus.mq_head     = '0;
        bus.launch_ack  = 1'b0;

        // Reset state
        #3;
        check("rst_valid",  {31'd0, bus.launch_valid}, 32'd0);
        check("rst_is_mq",  {31'd0, bus.launch_is_mq}, 32'd0);
        check("rst_cq_idx", {28'd0, bus.launch_cq_index}, 32'd0);
        check("rst_mq_idx", {30'd0, bus.launch_mq_index}, 32'd0);
        check_done("rst", 1'b0, 0, 1'b0, 0);
        tick();
        tick();
        nRST = 1'b1;

        // T1: wrap-around oldest-first, back-to-back ack, no duplicate launch
        bus.cq_head     = 4'd14;
        bus.cq_req_mask = 16'h8004;
        push(1'b0, 15);
        push(1'b0, 2);
        tick();
        pop_compare("t1_first", 1'b0);
        bus.launch_ack = 1'b1;
        #1;
        check_done("t1_ack15", 1'b1, 15, 1'b0, 0);
        tick();
        pop_compare("t1_second", 1'b1);
        bus.cq_req_mask = 16'h0004;
        tick();
        check("t1_no_dup", {31'd0, bus.launch_valid}, 32'd0);
        check("t1_idx_hold", {28'd0, bus.launch_cq_index}, 32'd2);
        bus.cq_req_mask = '0;
        bus.launch_ack  = 1'b0;
        #1;
        check_done("t1_idle", 1'b0, 0, 1'b0, 0);

        // T2: stall for 5 cycles while an MQ request appears, then MQ granted after ack
        bus.cq_head     = 4'd0;
        bus.cq_req_mask = 16'h0010;
        push(1'b0, 4);
        tick();
        pop_compare("t2_launch", 1'b0);
        bus.mq_head     = 2'd0;
        bus.mq_req_mask = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_valid", {31'd0, bus.launch_valid}, 32'd1);
            check("t2_stall_is_mq", {31'd0, bus.launch_is_mq}, 32'd0);
            check("t2_stall_idx",   {28'd0, bus.launch_cq_index}, 32'd4);
            check_done("t2_stall", 1'b0, 0, 1'b0, 0);
        end
        bus.launch_ack = 1'b1;
        push(1'b1, 1);
        #1;
        check_done("t2_ack4", 1'b1, 4, 1'b0, 0);
        tick();
        bus.cq_req_mask = '0;
        pop_compare("t2_mq", 1'b1);
        tick();
        check("t2_drain", {31'd0, bus.launch_valid}, 32'd0);
        bus.mq_req_mask = '0;
        bus.launch_ack  = 1'b0;

        // T3: anti-starvation after STARVE_LIMIT consecutive MQ grants
        bus.mq_head     = 2'd0;
        bus.mq_req_mask = 4'b1111;
        bus.cq_req_mask = 16'h0008;
        bus.launch_ack  = 1'b1;
        push(1'b1, 0);
        push(1'b1, 1);
        push(1'b1, 0);
        push(1'b1, 1);
        push(1'b0, 3);
        push(1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            pop_compare($sformatf("t3_grant%0d", i), 1'b1);
        end
        bus.mq_req_mask = '0;
        bus.cq_req_mask = '0;
        tick();
        check("t3_drain", {31'd0, bus.launch_valid}, 32'd0);
        bus.launch_ack = 1'b0;

        // T4: held entry killed before ack, re-arbitrated in the same cycle
        bus.cq_req_mask = 16'h0020;
        push(1'b0, 5);
        tick();
        pop_compare("t4_hold5", 1'b0);
        bus.cq_req_mask = 16'h0080;
        push(1'b0, 7);
        #1;
        check_done("t4_kill", 1'b0, 0, 1'b0, 0);
        tick();
        pop_compare("t4_relaunch7", 1'b0);
        bus.launch_ack = 1'b1;
        #1;
        check_done("t4_ack7", 1'b1, 7, 1'b0, 0);
        tick();
        check("t4_drain", {31'd0, bus.launch_valid}, 32'd0);
        bus.cq_req_mask = '0;
        bus.launch_ack  = 1'b0;

        // T5: MQ oldest-first with wrap (head 3, bits 0 and 2)
        bus.mq_head     = 2'd3;
        bus.mq_req_mask = 4'b0101;
        bus.launch_ack  = 1'b1;
        push(1'b1, 0);
        push(1'b1, 2);
        tick();
        pop_compare("t5_first", 1'b1);
        bus.mq_req_mask = 4'b0100;
        tick();
        pop_compare("t5_second", 1'b1);
        bus.mq_req_mask = '0;
        tick();
        check("t5_drain", {31'd0, bus.launch_valid}, 32'd0);
        check("t5_idx_hold", {30'd0, bus.launch_mq_index}, 32'd2);
        bus.launch_ack = 1'b0;

        // T6: reset mid-operation, then relaunch from current masks
        bus.cq_head     = 4'd0;
        bus.cq_req_mask = 16'h0200;
        push(1'b0, 9);
        tick();
        pop_compare("t6_launch", 1'b0);
        bus.launch_ack = 1'b1;
        nRST = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, bus.launch_valid}, 32'd0);
        check("t6_rst_cq_idx", {28'd0, bus.launch_cq_index}, 32'd0);
        check_done("t6_rst", 1'b0, 0, 1'b0, 0);
        tick();
        check("t6_rst_hold", {31'd0, bus.launch_valid}, 32'd0);
        bus.launch_ack = 1'b0;
        nRST = 1'b1;
        push(1'b0, 9);
        tick();
        pop_compare("t6_relaunch", 1'b0);
        bus.cq_req_mask = '0;
        tick();
        check("t6_kill_idle", {31'd0, bus.launch_valid}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
